// File: rtl/ldpc_enc.sv
// Systematic QC-LDPC encoder with dual-diagonal parity: streams K message blocks in, R codeword blocks out.
// Define LDPC_ENC_PARITY_ONLY_EN to emit only the C parity blocks and drop the message buffer.
module ldpc_enc #(
    parameter int data_w = 8,
    parameter int R      = 32,
    parameter int C      = 16,
    parameter int D      = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [C*(R-C)*data_w-1:0] mtx,
    input  logic [D-1:0]              msg,
    input  logic                      msg_valid,
    output logic                      msg_ready,
    output logic [D-1:0]              cw,
    output logic                      cw_valid,
    input  logic                      cw_ready,
    output logic                      cw_last,
    output logic                      busy
);
    localparam int K = R - C;
`ifdef LDPC_ENC_PARITY_ONLY_EN
    localparam int N_OUT = C;
    localparam int P_OFF = 0;
`else
    localparam int N_OUT = R;
    localparam int P_OFF = K;
`endif
    localparam int CNT_W  = (R > 1) ? $clog2(R) : 1;
    localparam int MEM_AW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, nxt_cnt;
    logic [D-1:0]     s_q [C];
    logic [D-1:0]     s_d [C];
    logic [D-1:0]     rot_blk [C];
    logic [D-1:0]     par_q, par_d;
    logic [D-1:0]     cw_q, cw_d;
    logic [D-1:0]     par_sel;
    logic             cw_valid_q, cw_valid_d;
    logic             cw_last_q, cw_last_d;
    logic             msg_fire, cw_fire;

    assign msg_ready = (state_q != EMIT);
    assign busy      = (state_q != IDLE);
    assign cw        = cw_q;
    assign cw_valid  = cw_valid_q;
    assign cw_last   = cw_last_q;
    assign msg_fire  = msg_valid && msg_ready;
    assign cw_fire   = cw_valid_q && cw_ready;
    assign nxt_cnt   = cnt_q + 1'b1;

    // Per block row: pick shift(i, cnt) and rotate the incoming block; shifts >= D mean a zero circulant.
    for (genvar gi = 0; gi < C; gi++) begin : g_row
        logic [data_w-1:0] sh;
        always_comb begin
            sh = '0;
            for (int j = 0; j < K; j++) begin
                if (cnt_q == CNT_W'(j)) sh = mtx[(gi*K + j)*data_w +: data_w];
            end
        end
        assign rot_blk[gi] = (int'(sh) >= D) ? '0
                           : ((msg >> sh) | (msg << (D - int'(sh))));
    end

    always_comb begin
        par_sel = '0;
        for (int i = 0; i < C; i++) begin
            if (nxt_cnt == CNT_W'(i + P_OFF)) par_sel = s_q[i];
        end
    end

`ifndef LDPC_ENC_PARITY_ONLY_EN
    logic [D-1:0] mem_q [K];
    logic [D-1:0] mem_rd;
    logic [D-1:0] first_blk;

    always_ff @(posedge clk) begin
        if (msg_fire) mem_q[cnt_q[MEM_AW-1:0]] <= msg;
    end

    assign mem_rd    = mem_q[nxt_cnt[MEM_AW-1:0]];
    // With a single message block the first codeword beat is the block arriving right now.
    assign first_blk = (K == 1) ? msg : mem_q[0];
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        par_d      = par_q;
        cw_d       = cw_q;
        cw_valid_d = cw_valid_q;
        cw_last_d  = cw_last_q;
        for (int i = 0; i < C; i++) s_d[i] = s_q[i];

        case (state_q)
            IDLE, LOAD: begin
                if (msg_fire) begin
                    for (int i = 0; i < C; i++) begin
                        s_d[i] = ((state_q == IDLE) ? '0 : s_q[i]) ^ rot_blk[i];
                    end
                    if (cnt_q == CNT_W'(K - 1)) begin
                        state_d    = EMIT;
                        cnt_d      = '0;
                        cw_valid_d = 1'b1;
                        cw_last_d  = (N_OUT == 1);
`ifdef LDPC_ENC_PARITY_ONLY_EN
                        cw_d       = s_d[0];
                        par_d      = s_d[0];
`else
                        cw_d       = first_blk;
                        par_d      = '0;
`endif
                    end else begin
                        state_d = LOAD;
                        cnt_d   = nxt_cnt;
                    end
                end
            end
            EMIT: begin
                if (cw_fire) begin
                    if (cw_last_q) begin
                        state_d    = IDLE;
                        cnt_d      = '0;
                        cw_valid_d = 1'b0;
                        cw_last_d  = 1'b0;
                        cw_d       = '0;
                        par_d      = '0;
                    end else begin
                        cnt_d     = nxt_cnt;
                        cw_last_d = (nxt_cnt == CNT_W'(N_OUT - 1));
`ifndef LDPC_ENC_PARITY_ONLY_EN
                        if (nxt_cnt < CNT_W'(P_OFF)) begin
                            cw_d = mem_rd;
                        end else begin
                            cw_d  = par_sel ^ par_q;
                            par_d = par_sel ^ par_q;
                        end
`else
                        cw_d  = par_sel ^ par_q;
                        par_d = par_sel ^ par_q;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            par_q      <= '0;
            cw_q       <= '0;
            cw_valid_q <= 1'b0;
            cw_last_q  <= 1'b0;
            for (int i = 0; i < C; i++) s_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            par_q      <= par_d;
            cw_q       <= cw_d;
            cw_valid_q <= cw_valid_d;
            cw_last_q  <= cw_last_d;
            for (int i = 0; i < C; i++) s_q[i] <= s_d[i];
        end
    end

endmodule

// File: tb/tb_ldpc_enc.sv
// Bench for ldpc_enc: directed vector table, reset-abort sequence, and randomized frames against a reference model.
module tb_ldpc_enc;
    localparam int DW = 8;
    localparam int R  = 32;
    localparam int C  = 16;
    localparam int D  = 64;
    localparam int K  = R - C;
`ifdef LDPC_ENC_PARITY_ONLY_EN
    localparam int N_OUT = C;
`else
    localparam int N_OUT = R;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [C*K*DW-1:0] mtx = '0;
    logic [D-1:0]      msg = '0;
    logic              msg_valid = 1'b0;
    logic              msg_ready;
    logic [D-1:0]      cw;
    logic              cw_valid;
    logic              cw_ready = 1'b0;
    logic              cw_last;
    logic              busy;

    int tests = 0;
    int fails = 0;

    int           sh_tab [C][K];
    logic [D-1:0] msg_blk [K];
    logic [D-1:0] exp_q [N_OUT];

    ldpc_enc #(.data_w(DW), .R(R), .C(C), .D(D)) dut (
        .clk(clk), .rst(rst), .mtx(mtx), .msg(msg), .msg_valid(msg_valid),
        .msg_ready(msg_ready), .cw(cw), .cw_valid(cw_valid), .cw_ready(cw_ready),
        .cw_last(cw_last), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [D-1:0] act, input logic [D-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic [D-1:0] rot(input logic [D-1:0] x, input int s);
        logic [D-1:0] r;
        r = '0;
        if (s >= D) return r;
        for (int k = 0; k < D; k++) r[k] = x[(k + s) % D];
        return r;
    endfunction

    task automatic pack_mtx();
        for (int i = 0; i < C; i++)
            for (int j = 0; j < K; j++)
                mtx[(i*K + j)*DW +: DW] = DW'(sh_tab[i][j]);
    endtask

    // Reference: syndrome rows from the circulant products, then the dual-diagonal back-substitution.
    task automatic model_expected();
        logic [D-1:0] s, p;
        p = '0;
        for (int i = 0; i < C; i++) begin
            s = '0;
            for (int j = 0; j < K; j++) s ^= rot(msg_blk[j], sh_tab[i][j]);
            p = s ^ p;
            exp_q[N_OUT - C + i] = p;
        end
        for (int j = 0; j < N_OUT - C; j++) exp_q[j] = msg_blk[j];
    endtask

    task automatic send_frame(input bit bubbles);
        int j = 0;
        int guard = 0;
        while (j < K) begin
            if (guard++ > 8*K + 20) begin
                fail_now("send_timeout");
                msg_valid = 1'b0;
                return;
            end
            check("msg_ready_load", D'(msg_ready), D'(1));
            check("busy_load", D'(busy), D'(j != 0));
            msg_valid = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
            msg = msg_valid ? msg_blk[j] : {$urandom, $urandom};
            if (msg_valid) j++;
            @(negedge clk);
        end
        msg_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: toggle 1/0 each cycle, 2: random. abort_at >= 0 pulses rst at that beat.
    task automatic recv_frame(input int mode, input int abort_at);
        int b = 0;
        int guard = 0;
        int tog = 0;
        logic stalled = 1'b0;
        logic [D-1:0] held_cw = '0;
        logic held_last = 1'b0;
        while (b < N_OUT) begin
            if (b == abort_at) begin
                msg_valid = 1'b0;
                cw_ready  = 1'b0;
                rst = 1'b1;
                #1;
                check("abort_cw_valid", D'(cw_valid), D'(0));
                check("abort_busy", D'(busy), D'(0));
                check("abort_cw", cw, '0);
                @(negedge clk);
                rst = 1'b0;
                #1;
                check("abort_msg_ready", D'(msg_ready), D'(1));
                check("abort_cw_valid_after", D'(cw_valid), D'(0));
                return;
            end
            if (guard++ > 4*N_OUT + 20) begin
                fail_now("recv_timeout");
                cw_ready = 1'b0;
                msg_valid = 1'b0;
                return;
            end
            check($sformatf("cw_valid_b%0d", b), D'(cw_valid), D'(1));
            check("msg_ready_emit", D'(msg_ready), D'(0));
            if (stalled) begin
                check($sformatf("stall_cw_b%0d", b), cw, held_cw);
                check($sformatf("stall_last_b%0d", b), D'(cw_last), D'(held_last));
            end
            case (mode)
                0:       cw_ready = 1'b1;
                1:       cw_ready = (tog % 2 == 0);
                default: cw_ready = 1'($urandom_range(0, 1));
            endcase
            tog++;
            msg_valid = 1'($urandom_range(0, 1));
            msg = {$urandom, $urandom};
            if (cw_ready && cw_valid) begin
                check($sformatf("cw_b%0d", b), cw, exp_q[b]);
                check($sformatf("cw_last_b%0d", b), D'(cw_last), D'(b == N_OUT - 1));
                b++;
                stalled = 1'b0;
            end else begin
                stalled   = 1'b1;
                held_cw   = cw;
                held_last = cw_last;
            end
            @(negedge clk);
        end
        msg_valid = 1'b0;
        cw_ready  = 1'b0;
        check("end_cw_valid", D'(cw_valid), D'(0));
        check("end_busy", D'(busy), D'(0));
    endtask

    typedef struct {
        int           sh00;
        logic [D-1:0] m0;
        logic [D-1:0] par;
        int           mode;
    } vec_t;

    task automatic setup_directed(input vec_t v);
        for (int i = 0; i < C; i++)
            for (int j = 0; j < K; j++) sh_tab[i][j] = 255;
        sh_tab[0][0] = v.sh00;
        for (int j = 0; j < K; j++) msg_blk[j] = '0;
        msg_blk[0] = v.m0;
        pack_mtx();
        for (int b = 0; b < N_OUT - C; b++) exp_q[b] = (b == 0) ? v.m0 : '0;
        for (int i = 0; i < C; i++) exp_q[N_OUT - C + i] = v.par;
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{sh00: 255, m0: 64'h0, par: 64'h0,                 mode: 0};
        vecs[1] = '{sh00: 0,   m0: 64'h1, par: 64'h1,                 mode: 0};
        vecs[2] = '{sh00: 1,   m0: 64'h1, par: 64'h8000_0000_0000_0000, mode: 0};
        vecs[3] = '{sh00: 0,   m0: 64'h1, par: 64'h1,                 mode: 1};
        vecs[4] = '{sh00: 63,  m0: 64'h1, par: 64'h2,                 mode: 0};
        vecs[5] = '{sh00: 64,  m0: 64'h1, par: 64'h0,                 mode: 2};
        vecs[6] = '{sh00: 2,   m0: 64'h3, par: 64'hC000_0000_0000_0000, mode: 1};

        #1;
        check("rst_cw_valid", D'(cw_valid), D'(0));
        check("rst_cw_last", D'(cw_last), D'(0));
        check("rst_busy", D'(busy), D'(0));
        check("rst_cw", cw, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_msg_ready", D'(msg_ready), D'(1));
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            setup_directed(vecs[v]);
            send_frame(1'b0);
            recv_frame(vecs[v].mode, -1);
            $display("[TB] directed frame %0d: shift00=%0d msg0=%h mode=%0d", v, vecs[v].sh00, vecs[v].m0, vecs[v].mode);
            @(negedge clk);
        end

        setup_directed(vecs[1]);
        send_frame(1'b0);
        recv_frame(0, (N_OUT > 20) ? 20 : N_OUT / 2);
        $display("[TB] reset-abort frame issued");
        @(negedge clk);
        setup_directed(vecs[1]);
        send_frame(1'b0);
        recv_frame(0, -1);
        $display("[TB] post-abort frame done");
        @(negedge clk);

        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < C; i++)
                for (int j = 0; j < K; j++) sh_tab[i][j] = $urandom_range(0, D + 16);
            for (int j = 0; j < K; j++) msg_blk[j] = {$urandom, $urandom};
            pack_mtx();
            model_expected();
            send_frame(1'(f % 2));
            recv_frame(f % 3, -1);
            $display("[TB] random frame %0d done", f);
            if (f % 2 == 0) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
